// File: rtl/p_dot_seq_pkg.sv
// Shared perceptron package: data configuration type, dot-sequencer states and
// saturation bound helpers.
`ifndef DEF_DCONF
`define DEF_DCONF '{sgn: 1'b1, prec: 8'd16}
`endif

package p_dot_seq_pkg;

   localparam int unsigned WIDE_W = 64;

   typedef struct packed {
      logic       sgn;
      logic [7:0] prec;
   } dconf_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } dot_state_t;

   // Largest representable value of a configuration, sign-extended to WIDE_W.
   function automatic logic signed [WIDE_W-1:0] sat_max(input dconf_t c);
      logic signed [WIDE_W-1:0] one;
      one = WIDE_W'(1);
      if (c.sgn) return (one <<< (c.prec - 8'd1)) - one;
      else       return (one <<< c.prec) - one;
   endfunction

   function automatic logic signed [WIDE_W-1:0] sat_min(input dconf_t c);
      logic signed [WIDE_W-1:0] one;
      one = WIDE_W'(1);
      if (c.sgn) return -(one <<< (c.prec - 8'd1));
      else       return '0;
   endfunction

endpackage

// File: rtl/p_dot_seq_if.sv
// Start/operand-read/result bundle between the dot sequencer and its environment.
interface p_dot_seq_if #(
   parameter int unsigned LEN_W  = 5,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned I1_W   = 16,
   parameter int unsigned I2_W   = 16,
   parameter int unsigned ACC_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [LEN_W-1:0]  len;
   logic [ACC_W-1:0]  bias;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [I1_W-1:0]   rd_data1;
   logic [I2_W-1:0]   rd_data2;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out;
   logic              ovf;

   modport master (
      output in_valid, len, bias, rd_data1, rd_data2, out_ready,
      input  in_ready, rd_en, rd_addr, out_valid, out, ovf
   );

   modport slave (
      input  in_valid, len, bias, rd_data1, rd_data2, out_ready,
      output in_ready, rd_en, rd_addr, out_valid, out, ovf
   );
endinterface

// File: rtl/p_int_mult.sv
// Combinational integer multiplier with mixed signedness, saturating into O_CONF.
module p_int_mult
   import p_dot_seq_pkg::*;
#(
   parameter dconf_t I1_CONF = `DEF_DCONF,
   parameter dconf_t I2_CONF = `DEF_DCONF,
   parameter dconf_t O_CONF  = `DEF_DCONF
) (
   input  logic [I1_CONF.prec-1:0] a,
   input  logic [I2_CONF.prec-1:0] b,
   output logic [O_CONF.prec-1:0]  prod,
   output logic                    ovf
);
   localparam int unsigned A_W = I1_CONF.prec;
   localparam int unsigned B_W = I2_CONF.prec;
   localparam int unsigned O_W = O_CONF.prec;
   localparam int unsigned P_W = A_W + B_W + 2;

   logic signed [A_W:0]        a_x;
   logic signed [B_W:0]        b_x;
   logic signed [P_W-1:0]      p_full;
   logic signed [WIDE_W-1:0]   p_w;
   logic signed [WIDE_W-1:0]   o_max;
   logic signed [WIDE_W-1:0]   o_min;

   // One guard bit per operand makes unsigned and signed inputs both exact signed values.
   always_comb begin
      a_x    = I1_CONF.sgn ? {a[A_W-1], a} : {1'b0, a};
      b_x    = I2_CONF.sgn ? {b[B_W-1], b} : {1'b0, b};
      p_full = P_W'(a_x) * P_W'(b_x);
      p_w    = WIDE_W'(p_full);
      o_max  = sat_max(O_CONF);
      o_min  = sat_min(O_CONF);
      prod   = O_W'(p_w);
      ovf    = 1'b0;
      if (p_w > o_max) begin
         prod = O_W'(o_max);
         ovf  = 1'b1;
      end else if (p_w < o_min) begin
         prod = O_W'(o_min);
         ovf  = 1'b1;
      end
   end
endmodule

// File: rtl/p_sat_acc.sv
// Registered saturating accumulator with sticky overflow; exposes its next state
// so callers can capture the post-update value on the same edge.
module p_sat_acc
   import p_dot_seq_pkg::*;
#(
   parameter dconf_t ACC_CONF = `DEF_DCONF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic [ACC_CONF.prec-1:0] load_val,
   input  logic                     add_en,
   input  logic [ACC_CONF.prec-1:0] add_val,
   input  logic                     add_ovf,
   output logic [ACC_CONF.prec-1:0] acc_nxt_c,
   output logic                     ovf_nxt_c
);
   localparam int unsigned   W       = ACC_CONF.prec;
   localparam bit            SGN     = ACC_CONF.sgn;
   localparam logic [W-1:0]  ACC_MAX = W'(sat_max(ACC_CONF));
   localparam logic [W-1:0]  ACC_MIN = W'(sat_min(ACC_CONF));

   logic [W-1:0] acc_q;
   logic         ovf_q;
   logic [W:0]   a_x;
   logic [W:0]   b_x;
   logic [W:0]   sum;
   logic         sat_hit;

   // Add one bit wider than the accumulator, then clamp on overflow.
   always_comb begin
      a_x       = SGN ? {acc_q[W-1], acc_q} : {1'b0, acc_q};
      b_x       = SGN ? {add_val[W-1], add_val} : {1'b0, add_val};
      sum       = a_x + b_x;
      sat_hit   = SGN ? (sum[W] ^ sum[W-1]) : sum[W];
      acc_nxt_c = acc_q;
      ovf_nxt_c = ovf_q;
      if (load) begin
         acc_nxt_c = load_val;
         ovf_nxt_c = 1'b0;
      end else if (add_en) begin
         if (!sat_hit)            acc_nxt_c = sum[W-1:0];
         else if (SGN && sum[W])  acc_nxt_c = ACC_MIN;
         else                     acc_nxt_c = ACC_MAX;
         ovf_nxt_c = ovf_q | sat_hit | add_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_nxt_c;
         ovf_q <= ovf_nxt_c;
      end
   end
endmodule

// File: rtl/p_dot_seq.sv
// Dot-product sequencer: bias + sum(in1[i]*in2[i]) over a fixed-latency read port.
// Define P_DOT_SEQ_RELU_EN to clamp negative signed results to zero on output.
module p_dot_seq
   import p_dot_seq_pkg::*;
#(
   parameter dconf_t      I1_CONF  = `DEF_DCONF,
   parameter dconf_t      I2_CONF  = `DEF_DCONF,
   parameter dconf_t      ACC_CONF = `DEF_DCONF,
   parameter int unsigned VEC_LEN  = 16,
   parameter int unsigned LEN_W    = $clog2(VEC_LEN + 1),
   parameter int unsigned ADDR_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
   input  logic         clk,
   input  logic         reset,
   p_dot_seq_if.slave   bus
);
   localparam int unsigned      ACC_W     = ACC_CONF.prec;
   localparam logic [LEN_W-1:0] VEC_LEN_L = LEN_W'(VEC_LEN);

   dot_state_t       state;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] len_q;
   logic             p1_vld;
   logic             p2_vld;
   logic [ACC_W-1:0] prod_q;
   logic             mult_ovf_q;
   logic [ACC_W-1:0] mult_prod;
   logic             mult_ovf;
   logic [ACC_W-1:0] acc_nxt_c;
   logic             ovf_nxt_c;
   logic             load_c;

   function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] v);
`ifdef P_DOT_SEQ_RELU_EN
      return (ACC_CONF.sgn && v[ACC_W-1]) ? '0 : v;
`else
      return v;
`endif
   endfunction

   assign load_c = (state == IDLE) && bus.in_valid;

   p_int_mult #(
      .I1_CONF (I1_CONF),
      .I2_CONF (I2_CONF),
      .O_CONF  (ACC_CONF)
   ) u_mult (
      .a    (bus.rd_data1),
      .b    (bus.rd_data2),
      .prod (mult_prod),
      .ovf  (mult_ovf)
   );

   p_sat_acc #(
      .ACC_CONF (ACC_CONF)
   ) u_acc (
      .clk       (clk),
      .reset     (reset),
      .load      (load_c),
      .load_val  (bus.bias),
      .add_en    (p2_vld),
      .add_val   (prod_q),
      .add_ovf   (mult_ovf_q),
      .acc_nxt_c (acc_nxt_c),
      .ovf_nxt_c (ovf_nxt_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.rd_en     <= 1'b0;
         bus.rd_addr   <= '0;
         bus.out_valid <= 1'b0;
         bus.out       <= '0;
         bus.ovf       <= 1'b0;
         cnt           <= '0;
         len_q         <= '0;
         p1_vld        <= 1'b0;
         p2_vld        <= 1'b0;
         prod_q        <= '0;
         mult_ovf_q    <= 1'b0;
      end else begin
         p1_vld <= bus.rd_en;
         p2_vld <= p1_vld;
         if (p1_vld) begin
            prod_q     <= mult_prod;
            mult_ovf_q <= mult_ovf;
         end

         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  len_q        <= (bus.len > VEC_LEN_L) ? VEC_LEN_L : bus.len;
                  bus.in_ready <= 1'b0;
                  if (bus.len == '0) begin
                     state         <= DONE;
                     bus.out_valid <= 1'b1;
                     bus.out       <= relu(acc_nxt_c);
                     bus.ovf       <= ovf_nxt_c;
                     cnt           <= '0;
                  end else begin
                     state       <= RUN;
                     bus.rd_en   <= 1'b1;
                     bus.rd_addr <= '0;
                     cnt         <= LEN_W'(1);
                  end
               end
            end
            RUN: begin
               if (cnt == len_q) begin
                  bus.rd_en <= 1'b0;
                  state     <= DRAIN;
               end else begin
                  bus.rd_addr <= ADDR_W'(cnt);
                  cnt         <= cnt + LEN_W'(1);
               end
            end
            // Once p1 is empty, p2's last product lands in the accumulator on this edge.
            DRAIN: begin
               if (!p1_vld) begin
                  state         <= DONE;
                  bus.out_valid <= 1'b1;
                  bus.out       <= relu(acc_nxt_c);
                  bus.ovf       <= ovf_nxt_c;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_p_dot_seq.sv
// Directed bench: three p_dot_seq configurations (u8*u8->u16, s8*s8->s16, s8*s8->s8)
// run in lockstep on shared stimulus and a shared operand memory.
module tb_p_dot_seq;
   import p_dot_seq_pkg::*;

   localparam dconf_t U8  = '{sgn: 1'b0, prec: 8'd8};
   localparam dconf_t S8  = '{sgn: 1'b1, prec: 8'd8};
   localparam dconf_t U16 = '{sgn: 1'b0, prec: 8'd16};
   localparam dconf_t S16 = '{sgn: 1'b1, prec: 8'd16};

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [4:0]  len;
   logic [15:0] bias;
   logic [7:0]  rd_data1 = '0;
   logic [7:0]  rd_data2 = '0;
   logic [7:0]  mem1 [16];
   logic [7:0]  mem2 [16];
   int          n_chk  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   p_dot_seq_if #(.LEN_W(5), .ADDR_W(4), .I1_W(8), .I2_W(8), .ACC_W(16)) if_u16 ();
   p_dot_seq_if #(.LEN_W(5), .ADDR_W(4), .I1_W(8), .I2_W(8), .ACC_W(16)) if_s16 ();
   p_dot_seq_if #(.LEN_W(5), .ADDR_W(4), .I1_W(8), .I2_W(8), .ACC_W(8))  if_s8 ();

   assign if_u16.in_valid = in_valid;   assign if_s16.in_valid = in_valid;   assign if_s8.in_valid = in_valid;
   assign if_u16.out_ready = out_ready; assign if_s16.out_ready = out_ready; assign if_s8.out_ready = out_ready;
   assign if_u16.len = len;             assign if_s16.len = len;             assign if_s8.len = len;
   assign if_u16.bias = bias;           assign if_s16.bias = bias;           assign if_s8.bias = bias[7:0];
   assign if_u16.rd_data1 = rd_data1;   assign if_s16.rd_data1 = rd_data1;   assign if_s8.rd_data1 = rd_data1;
   assign if_u16.rd_data2 = rd_data2;   assign if_s16.rd_data2 = rd_data2;   assign if_s8.rd_data2 = rd_data2;

   p_dot_seq #(.I1_CONF(U8), .I2_CONF(U8), .ACC_CONF(U16), .VEC_LEN(16)) u_u16 (.clk(clk), .reset(reset), .bus(if_u16));
   p_dot_seq #(.I1_CONF(S8), .I2_CONF(S8), .ACC_CONF(S16), .VEC_LEN(16)) u_s16 (.clk(clk), .reset(reset), .bus(if_s16));
   p_dot_seq #(.I1_CONF(S8), .I2_CONF(S8), .ACC_CONF(S8),  .VEC_LEN(16)) u_s8  (.clk(clk), .reset(reset), .bus(if_s8));

   // Operand memory with one cycle of read latency.
   always @(posedge clk) begin
      if (if_s16.rd_en) begin
         rd_data1 <= mem1[if_s16.rd_addr];
         rd_data2 <= mem2[if_s16.rd_addr];
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int rl(input int v);
`ifdef P_DOT_SEQ_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic fill(input logic [7:0] a, input logic [7:0] b);
      for (int i = 0; i < 16; i++) begin
         mem1[i] = a;
         mem2[i] = b;
      end
   endtask

   // One transaction: start, follow reads, wait for the result and check all three DUTs.
   task automatic run(input string tag, input int n, input logic [15:0] b,
                      input int e_u, input int e_s16, input int e_s8,
                      input int o_u, input int o_s16, input int o_s8, input bit hold);
      int eff, c, nrd, lat;
      bit seen;
      eff = (n > 16) ? 16 : n;
      lat = (eff == 0) ? 1 : eff + 3;
      @(negedge clk);
      out_ready = !hold;
      len       = 5'(n);
      bias      = b;
      in_valid  = 1'b1;
      check({tag, ":in_ready"}, int'(if_s16.in_ready), 1);
      @(posedge clk);
      nrd  = 0;
      seen = 1'b0;
      for (c = 1; c <= 60; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (if_s16.rd_en) begin
            check({tag, ":rd_addr"}, int'(if_s16.rd_addr), c - 1);
            nrd++;
         end
         if (if_s16.out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, ":seen"}, int'(seen), 1);
      check({tag, ":latency"}, c, lat);
      check({tag, ":reads"}, nrd, eff);
      check({tag, ":out_u16"}, int'(if_u16.out), e_u);
      check({tag, ":out_s16"}, int'(signed'(if_s16.out)), rl(e_s16));
      check({tag, ":out_s8"}, int'(signed'(if_s8.out)), rl(e_s8));
      check({tag, ":ovf_u16"}, int'(if_u16.ovf), o_u);
      check({tag, ":ovf_s16"}, int'(if_s16.ovf), o_s16);
      check({tag, ":ovf_s8"}, int'(if_s8.ovf), o_s8);
      if (!hold) @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bit seen;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      len       = '0;
      bias      = '0;
      fill(8'd0, 8'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst:in_ready", int'(if_s16.in_ready), 1);
      check("rst:rd_en", int'(if_s16.rd_en), 0);
      check("rst:rd_addr", int'(if_s16.rd_addr), 0);
      check("rst:out_valid", int'(if_s16.out_valid), 0);
      check("rst:out", int'(if_u16.out), 0);
      check("rst:ovf", int'(if_s8.ovf), 0);
      reset = 1'b0;

      fill(8'd0, 8'd2);
      mem1[0] = 8'd1; mem1[1] = 8'd2; mem1[2] = 8'd3; mem1[3] = 8'd4;
      run("dot4", 4, 16'd5, 25, 25, 25, 0, 0, 0, 1'b0);

      mem1[0] = 8'hFD; mem1[1] = 8'd4; mem2[0] = 8'd5; mem2[1] = 8'hFE;
      run("neg2", 2, 16'd0, 2281, -23, -23, 0, 0, 0, 1'b0);

      mem1[0] = 8'd5; mem2[0] = 8'd3;
      run("sat_pos", 1, 16'd120, 135, 135, 127, 0, 0, 1, 1'b0);

      mem1[0] = 8'hFB;
      run("sat_neg", 1, 16'hFF88, 65535, -135, -128, 1, 0, 1, 1'b0);

      mem1[0] = 8'd100; mem2[0] = 8'd100;
      run("mult_ovf", 1, 16'd0, 10000, 10000, 127, 0, 0, 1, 1'b0);

      run("len0", 0, 16'hFFF9, 65529, -7, -7, 0, 0, 0, 1'b0);

      fill(8'd1, 8'd1);
      run("clamp", 20, 16'd0, 16, 16, 16, 0, 0, 0, 1'b0);

      // Backpressure in DONE while a new start is requested.
      fill(8'd0, 8'd2);
      mem1[0] = 8'd1; mem1[1] = 8'd2; mem1[2] = 8'd3; mem1[3] = 8'd4;
      run("hold", 4, 16'd5, 25, 25, 25, 0, 0, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         @(negedge clk);
         check("hold:out", int'(if_u16.out), 25);
         check("hold:ovf", int'(if_u16.ovf), 0);
         check("hold:in_ready", int'(if_s16.in_ready), 0);
         check("hold:rd_en", int'(if_s16.rd_en), 0);
         check("hold:out_valid", int'(if_s16.out_valid), 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("hs:in_ready", int'(if_s16.in_ready), 1);
      check("hs:out_valid", int'(if_s16.out_valid), 0);
      check("hs:rd_en", int'(if_s16.rd_en), 0);
      @(negedge clk);
      in_valid = 1'b0;
      check("restart:rd_en", int'(if_s16.rd_en), 1);
      check("restart:in_ready", int'(if_s16.in_ready), 0);
      seen = 1'b0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (if_s16.out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("restart:seen", int'(seen), 1);
      check("restart:latency", k, 5);
      check("restart:out", int'(if_u16.out), 25);
      @(posedge clk);

      // Reset in the middle of a len=8 run.
      fill(8'd9, 8'd9);
      @(negedge clk);
      len      = 5'd8;
      bias     = 16'd3;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("abort:rd_en", int'(if_s16.rd_en), 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort:rd_en_off", int'(if_s16.rd_en), 0);
      check("abort:in_ready", int'(if_s16.in_ready), 1);
      check("abort:out_valid", int'(if_s16.out_valid), 0);
      check("abort:ovf", int'(if_s16.ovf), 0);
      reset = 1'b0;
      @(negedge clk);
      check("abort:quiet", int'(if_s16.rd_en), 0);

      fill(8'd0, 8'd0);
      mem1[0] = 8'd6; mem2[0] = 8'd7;
      run("post_rst", 1, 16'd10, 52, 52, 52, 0, 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
